// File: rtl/config_cmd_if.sv
// Bundle between the USB FIFO receiver, the command decoder and the config bus.
// The decoder sits on the slave side: it consumes bytes and produces register writes.
interface config_cmd_if;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic [15:0] config_addr;
    logic [15:0] config_data;
    logic        config_strobe;
    logic        packet_done;
    logic [7:0]  err_count;

    modport master (
        output rx_data,
        output rx_strobe,
        input  config_addr,
        input  config_data,
        input  config_strobe,
        input  packet_done,
        input  err_count
    );

    modport slave (
        input  rx_data,
        input  rx_strobe,
        output config_addr,
        output config_data,
        output config_strobe,
        output packet_done,
        output err_count
    );
endinterface

// File: rtl/config_cmd_decoder.sv
// Turns framed USB bytes (header, 3 address bytes, N x 3 data bytes) into config
// register writes with address auto-increment, resyncing on framing errors and stalls.
module config_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic        mclk,
    input  logic        reset,
    config_cmd_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR0,
        ADDR1,
        ADDR2,
        DATA0,
        DATA1,
        DATA2
    } state_t;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t                   state_q, state_d;
    logic [15:0]              workAddr_q;
    logic [15:0]              dataShift_q;
    logic [15:0]              configAddr_q;
    logic [15:0]              configData_q;
    logic [6:0]               remaining_q;
    logic [TIMEOUT_WIDTH-1:0] toCnt_q;
    logic                     configStrobe_q;
    logic                     packetDone_q;
    logic [7:0]               errCount_q;

    logic        isHeader;
    logic        isPayload;
    logic        timeoutHit;
    logic        emitWord;
    logic        lastWord;
    logic        errEvent;
    logic        shiftAddr;
    logic        finishAddr;
    logic        shiftData;
    logic [15:0] wordValue;

    assign isHeader  = bus.rx_strobe &  bus.rx_data[7];
    assign isPayload = bus.rx_strobe & ~bus.rx_data[7];
    // An arriving byte always beats the timeout on the same cycle.
    assign timeoutHit = TIMEOUT_EN && (state_q != IDLE) && !bus.rx_strobe
                        && (toCnt_q == TIMEOUT_LAST);
    assign wordValue  = {dataShift_q[13:0], bus.rx_data[1:0]};

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (isHeader) begin
            state_d = ADDR0;
        end else if (isPayload) begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ADDR0:   state_d = ADDR1;
                ADDR1:   state_d = ADDR2;
                ADDR2:   state_d = DATA0;
                DATA0:   state_d = DATA1;
                DATA1:   state_d = DATA2;
                DATA2:   state_d = (remaining_q == 7'd0) ? IDLE : DATA0;
                default: state_d = IDLE;
            endcase
        end else if (timeoutHit) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        emitWord   = 1'b0;
        errEvent   = 1'b0;
        shiftAddr  = 1'b0;
        finishAddr = 1'b0;
        shiftData  = 1'b0;
        case (state_q)
            IDLE:         errEvent   = isPayload;
            ADDR0, ADDR1: shiftAddr  = isPayload;
            ADDR2:        finishAddr = isPayload;
            DATA0, DATA1: shiftData  = isPayload;
            DATA2:        emitWord   = isPayload;
            default:      ;
        endcase
        if ((state_q != IDLE) && (isHeader || timeoutHit)) begin
            errEvent = 1'b1;
        end
        lastWord = emitWord && (remaining_q == 7'd0);
    end

    // Each value arrives as 7 + 7 + 2 bits, so shifting left fills exactly 16 bits.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            workAddr_q     <= '0;
            dataShift_q    <= '0;
            configAddr_q   <= '0;
            configData_q   <= '0;
            remaining_q    <= '0;
            toCnt_q        <= '0;
            configStrobe_q <= 1'b0;
            packetDone_q   <= 1'b0;
            errCount_q     <= '0;
        end else begin
            configStrobe_q <= emitWord;
            packetDone_q   <= lastWord;

            if (isHeader) begin
                remaining_q <= bus.rx_data[6:0];
            end else if (emitWord && (remaining_q != 7'd0)) begin
                remaining_q <= remaining_q - 7'd1;
            end

            if (shiftAddr) begin
                workAddr_q <= {workAddr_q[8:0], bus.rx_data[6:0]};
            end else if (finishAddr) begin
                workAddr_q <= {workAddr_q[13:0], bus.rx_data[1:0]};
            end else if (emitWord) begin
                workAddr_q <= workAddr_q + 16'd1;
            end

            if (shiftData) begin
                dataShift_q <= {dataShift_q[8:0], bus.rx_data[6:0]};
            end

            if (emitWord) begin
                configAddr_q <= workAddr_q;
                configData_q <= wordValue;
            end

            if (errEvent && (errCount_q != 8'hff)) begin
                errCount_q <= errCount_q + 8'd1;
            end

            if (bus.rx_strobe || (state_q == IDLE)) begin
                toCnt_q <= '0;
            end else begin
                toCnt_q <= toCnt_q + 1'b1;
            end
        end
    end

    assign bus.config_addr   = configAddr_q;
    assign bus.config_data   = configData_q;
    assign bus.config_strobe = configStrobe_q;
    assign bus.packet_done   = packetDone_q;
    assign bus.err_count     = errCount_q;

endmodule

// File: tb/tb_config_cmd_decoder.sv
// Bench for config_cmd_decoder: table-driven packets plus hand-written resync,
// timeout and reset sequences, checked by a cycle-accurate write scoreboard.
module tb_config_cmd_decoder;

    typedef struct {
        logic [6:0]       nm1;
        logic [15:0]      addr;
        logic [3:0][15:0] data;
        int               gap;
        logic [7:0]       expErr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        done;
        int          edgeNo;
    } exp_t;

    logic mclk = 1'b0;
    logic reset;
    config_cmd_if bus ();

    config_cmd_decoder #(
        .TIMEOUT_CYCLES(100),
        .TIMEOUT_WIDTH (16)
    ) dut (
        .mclk (mclk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 mclk = ~mclk;

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycleCount  = 0;
    int   lastEdge    = 0;
    exp_t expQ[$];
    vec_t vecs[4];

    always @(posedge mclk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveByte(input logic [7:0] b);
        @(negedge mclk);
        bus.rx_data   = b;
        bus.rx_strobe = 1'b1;
        lastEdge      = cycleCount + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge mclk);
            bus.rx_strobe = 1'b0;
            bus.rx_data   = 8'h00;
        end
    endtask

    task automatic sendValue(input logic [15:0] v, input int gap);
        driveByte({1'b0, v[15:9]});
        idle(gap);
        driveByte({1'b0, v[8:2]});
        idle(gap);
        driveByte({6'b0, v[1:0]});
    endtask

    // The write must appear in the cycle right after its last data byte.
    task automatic expectWrite(input logic [15:0] a, input logic [15:0] d, input logic done);
        exp_t e;
        e.addr   = a;
        e.data   = d;
        e.done   = done;
        e.edgeNo = lastEdge;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        driveByte({1'b1, v.nm1});
        idle(v.gap);
        sendValue(v.addr, v.gap);
        for (int i = 0; i <= int'(v.nm1); i++) begin
            idle(v.gap);
            sendValue(v.data[i], v.gap);
            expectWrite(v.addr + 16'(i), v.data[i], i == int'(v.nm1));
        end
        idle(4);
        checkOutput("err_after_packet", {24'h0, bus.err_count}, {24'h0, v.expErr});
    endtask

    always @(posedge mclk) begin
        exp_t e;
        #1;
        if (bus.config_strobe === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_strobe", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("write_addr", {16'h0, bus.config_addr}, {16'h0, e.addr});
                checkOutput("write_data", {16'h0, bus.config_data}, {16'h0, e.data});
                checkOutput("packet_done", {31'h0, bus.packet_done}, {31'h0, e.done});
                checkOutput("write_cycle", cycleCount, e.edgeNo);
            end
        end else begin
            if (bus.packet_done === 1'b1) begin
                checkOutput("done_without_strobe", 32'd1, 32'd0);
            end
            if (expQ.size() > 0 && expQ[0].edgeNo < cycleCount) begin
                e = expQ.pop_front();
                checkOutput("missing_strobe_addr", 32'hdead, {16'h0, e.addr});
            end
        end
    end

    initial begin
        logic [7:0] raw1[7];
        logic [7:0] raw2[7];
        logic [15:0] toAddr;

        raw1 = '{8'h80, 8'h38, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h03};
        raw2 = '{8'h80, 8'h38, 8'h00, 8'h7D, 8'h00, 8'h0A, 8'h7F};

        vecs[0].nm1 = 7'd2; vecs[0].addr = 16'h8000; vecs[0].gap = 0; vecs[0].expErr = 8'd0;
        vecs[0].data[0] = 16'h1234; vecs[0].data[1] = 16'hABCD; vecs[0].data[2] = 16'hFFFF;
        vecs[0].data[3] = 16'h0000;
        vecs[1].nm1 = 7'd1; vecs[1].addr = 16'hFFFF; vecs[1].gap = 0; vecs[1].expErr = 8'd0;
        vecs[1].data[0] = 16'h5A5A; vecs[1].data[1] = 16'h0001;
        vecs[1].data[2] = 16'h0000; vecs[1].data[3] = 16'h0000;
        vecs[2].nm1 = 7'd3; vecs[2].addr = 16'h7800; vecs[2].gap = 2; vecs[2].expErr = 8'd0;
        vecs[2].data[0] = 16'h0000; vecs[2].data[1] = 16'h8001; vecs[2].data[2] = 16'h7FFE;
        vecs[2].data[3] = 16'h3C3C;
        vecs[3].nm1 = 7'd0; vecs[3].addr = 16'h9FFF; vecs[3].gap = 1; vecs[3].expErr = 8'd0;
        vecs[3].data[0] = 16'hC0DE; vecs[3].data[1] = 16'h0000;
        vecs[3].data[2] = 16'h0000; vecs[3].data[3] = 16'h0000;

        reset         = 1'b1;
        bus.rx_data   = 8'h00;
        bus.rx_strobe = 1'b0;
        repeat (3) @(negedge mclk);
        checkOutput("reset_addr", {16'h0, bus.config_addr}, 32'h0);
        checkOutput("reset_data", {16'h0, bus.config_data}, 32'h0);
        checkOutput("reset_strobe", {31'h0, bus.config_strobe}, 32'h0);
        checkOutput("reset_done", {31'h0, bus.packet_done}, 32'h0);
        checkOutput("reset_err", {24'h0, bus.err_count}, 32'h0);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 7; i++) driveByte(raw1[i]);
        expectWrite(16'h7000, 16'h002B, 1'b1);
        idle(3);
        checkOutput("single_err", {24'h0, bus.err_count}, 32'h0);
        for (int i = 0; i < 7; i++) driveByte(raw2[i]);
        expectWrite(16'h7001, 16'h002B, 1'b1);
        idle(3);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        driveByte(8'h83);
        sendValue(16'h2000, 0);
        sendValue(16'h1111, 0);
        expectWrite(16'h2000, 16'h1111, 1'b0);
        driveByte(8'h22);
        driveByte(8'h80);
        sendValue(16'h2100, 0);
        sendValue(16'h0BEE, 0);
        expectWrite(16'h2100, 16'h0BEE, 1'b1);
        idle(3);
        checkOutput("resync_err", {24'h0, bus.err_count}, 32'd1);
        driveByte(8'h15);
        idle(2);
        checkOutput("stray_err", {24'h0, bus.err_count}, 32'd2);

        // A byte landing on the 100th quiet cycle still belongs to the packet.
        toAddr = 16'h7800;
        driveByte(8'h80);
        driveByte({1'b0, toAddr[15:9]});
        driveByte({1'b0, toAddr[8:2]});
        idle(99);
        driveByte({6'b0, toAddr[1:0]});
        sendValue(16'h4321, 0);
        expectWrite(16'h7800, 16'h4321, 1'b1);
        idle(3);
        checkOutput("timeout_edge_err", {24'h0, bus.err_count}, 32'd2);

        toAddr = 16'h7810;
        driveByte(8'h80);
        driveByte({1'b0, toAddr[15:9]});
        driveByte({1'b0, toAddr[8:2]});
        idle(101);
        checkOutput("timeout_err", {24'h0, bus.err_count}, 32'd3);
        driveByte(8'h80);
        sendValue(16'h7810, 0);
        sendValue(16'h0055, 0);
        expectWrite(16'h7810, 16'h0055, 1'b1);
        idle(3);
        checkOutput("after_timeout_err", {24'h0, bus.err_count}, 32'd3);

        for (int i = 0; i < 300; i++) begin
            driveByte(8'h01);
            idle(1);
        end
        idle(2);
        checkOutput("err_saturate", {24'h0, bus.err_count}, 32'hff);

        driveByte(8'h82);
        sendValue(16'h8100, 0);
        sendValue(16'h1357, 0);
        expectWrite(16'h8100, 16'h1357, 1'b0);
        driveByte(8'h11);
        @(posedge mclk);
        #3 reset = 1'b1;
        #1;
        checkOutput("async_reset_addr", {16'h0, bus.config_addr}, 32'h0);
        checkOutput("async_reset_data", {16'h0, bus.config_data}, 32'h0);
        checkOutput("async_reset_strobe", {31'h0, bus.config_strobe}, 32'h0);
        checkOutput("async_reset_done", {31'h0, bus.packet_done}, 32'h0);
        checkOutput("async_reset_err", {24'h0, bus.err_count}, 32'h0);
        idle(3);
        reset = 1'b0;
        idle(2);
        vecs[0].nm1 = 7'd1; vecs[0].addr = 16'h8200; vecs[0].gap = 0; vecs[0].expErr = 8'd0;
        vecs[0].data[0] = 16'h2468; vecs[0].data[1] = 16'h1001;
        applyStimulus(vecs[0]);

        idle(10);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
